bicubic_sched: RTL and testbench
================================

# bicubic_sched

Frame-level scheduler for the three-channel bicubic upsample datapath. Sits between the line buffer and the R/G/B `bicubic_upsample` instances. It walks the source image in raster order and forks each 4x4 window request to the three channels with a correct per-channel handshake. It joins the three channel responses, bounds in-flight windows with a credit counter, and reports frame start, busy and done.

## Interface
- `IMG_WIDTH`, 960: source windows per row.
- `IMG_HEIGHT`, 540: source rows per frame.
- `MAX_OUTSTANDING`, 4: maximum accepted-but-unanswered windows; legal range 1..15.
- `CNT_WIDTH`, 12: width of coordinate counters.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: frame start pulse; honoured only in IDLE.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at frame completion.
- `bf_req_valid` in 1: buffer presents a window.
- `sched_req_ready` out 1: window consumed by all three channels.
- `ch_req_valid` out 3: per-channel request valid; bit 2 = R, bit 1 = G, bit 0 = B.
- `ch_req_ready` in 3: per-channel request ready.
- `req_x`, `req_y` out CNT_WIDTH each: source coordinate of the window currently offered.
- `ch_rsp_valid` in 3: per-channel response valid.
- `ch_rsp_ready` out 3: per-channel response ready.
- `sched_rsp_valid` out 1: joined 2x2 RGB result valid toward the buffer.
- `bf_rsp_ready` in 1: buffer accepts the result.
- `rsp_x`, `rsp_y` out CNT_WIDTH each: source coordinate of the result; output pixels are (2*rsp_x..+1, 2*rsp_y..+1).
- `perf_stall_cycles` out 32: stall counter (see Configuration).

## Operation
- States and transitions:
  - IDLE -> RUN on `start`.
  - RUN -> DRAIN when the last window (IMG_WIDTH-1, IMG_HEIGHT-1) issues.
  - DRAIN -> DONE when the last response handshakes.
  - DONE -> IDLE unconditionally, after one cycle.
- `start` outside IDLE is ignored.
- Request fork:
  - `can_issue` = state RUN & `credits < MAX_OUTSTANDING`.
  - `ch_req_valid[i]` = `bf_req_valid & can_issue & ~acc[i]`.
  - `acc[i]` is set on `ch_req_valid[i] & ch_req_ready[i]`.
  - `sched_req_ready` = `bf_req_valid & can_issue & &(acc | (ch_req_valid & ch_req_ready))`.
  - An issue occurs when `sched_req_ready` is high. On issue, `acc` clears to 0, `credits` +1 and `req_x/req_y` advance in raster order: x wraps at IMG_WIDTH-1 to 0 and y increments.
- Response join:
  - `sched_rsp_valid` = `&ch_rsp_valid`.
  - `ch_rsp_ready[i]` = `bf_rsp_ready & &ch_rsp_valid`. All three channels retire together, never individually.
  - On a response handshake, `credits` -1 and `rsp_x/rsp_y` advance in raster order.
- Simultaneous issue and response in one cycle: `credits` unchanged.
- `credits` width is 4 bits; it never exceeds MAX_OUTSTANDING and never underflows. A response handshake with `credits == 0` is impossible by construction; the bench must assert this.
- Responses return in issue order; the block relies on it for `rsp_x/rsp_y`.
- Outside RUN, `ch_req_valid` = 0 and `sched_req_ready` = 0. Responses are still joined in RUN and DRAIN. In IDLE and DONE, `ch_rsp_ready` = 0.

## Timing
- Reset values:
  - state = IDLE; `busy`, `done` = 0.
  - `acc` = 0, `credits` = 0.
  - `req_x`, `req_y`, `rsp_x`, `rsp_y` = 0.
  - `ch_req_valid`, `sched_req_ready`, `ch_rsp_ready`, `sched_rsp_valid` = 0.
  - `perf_stall_cycles` = 0.
- `start` at cycle N: `busy` = 1 at N+1 and the first request can issue at N+1.
- Fork/join paths are combinational, with zero added latency. When all channels are ready, one window issues per cycle until credits run out.
- Last response handshake at cycle M: `busy` = 0 and `done` = 1 at M+1, IDLE at M+2. The coordinate counters are back at 0 at M+1.
- A channel that accepted early keeps its valid low until the window issues. A window is therefore never delivered twice to any channel.
- `rst_n` asserted mid-frame: all state clears immediately to IDLE, and in-flight credits are discarded. The upstream blocks are reset by the same `rst_n`.

## Configuration
- `BICUBIC_SCHED_PERF_EN` defined:
  - `perf_stall_cycles` counts cycles in RUN with `bf_req_valid` = 1 and no issue. It saturates at 2^32-1.
  - It clears on `start` accepted.
- Not defined: `perf_stall_cycles` is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Basic frame: IMG_WIDTH=4, IMG_HEIGHT=2, all readys tied 1, responses returned 2 cycles after issue.
  - 8 issues in 8 consecutive cycles.
  - `rsp_x/rsp_y` sequence (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1).
  - `done` pulses exactly once, one cycle after the 8th response.
- Skewed ready: `ch_req_ready` = 3'b100 for cycle 1, 3'b010 for cycle 2, 3'b001 for cycle 3.
  - Each channel's valid drops after its own accept.
  - `sched_req_ready` pulses only in cycle 3; `req_x` 0 -> 1.
- Credit limit: MAX_OUTSTANDING=2, responses withheld.
  - Exactly 2 issues, then `sched_req_ready` held 0.
  - Releasing one response allows exactly one more issue.
- Partial response valid: `ch_rsp_valid` = 3'b110 for 5 cycles.
  - `ch_rsp_ready` = 0 and `sched_rsp_valid` = 0 throughout.
  - Raising bit 0 completes the handshake in that cycle.
- Reset mid-frame: deassert `rst_n` after 3 issues.
  - All outputs return to reset values.
  - A new `start` restarts from `req_x/req_y` = (0,0) with `credits` = 0.
- Perf counter (macro defined): 5 credit-stall cycles with `bf_req_valid` = 1 -> `perf_stall_cycles` = 5. Without the macro it reads 0.

Source files
------------

// File: rtl/bicubic_sched.sv
// bicubic_sched: raster-order window scheduler for the three-channel (R/G/B)
// bicubic upsample datapath. Forks each window request to all three channels,
// joins their responses, and bounds in-flight windows with a credit counter.
// Optional feature macro: BICUBIC_SCHED_PERF_EN (builds the stall counter).
module bicubic_sched #(
    parameter int IMG_WIDTH       = 960,
    parameter int IMG_HEIGHT      = 540,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 bf_req_valid,
    output logic                 sched_req_ready,
    output logic [2:0]           ch_req_valid,
    input  logic [2:0]           ch_req_ready,
    output logic [CNT_WIDTH-1:0] req_x,
    output logic [CNT_WIDTH-1:0] req_y,
    input  logic [2:0]           ch_rsp_valid,
    output logic [2:0]           ch_rsp_ready,
    output logic                 sched_rsp_valid,
    input  logic                 bf_rsp_ready,
    output logic [CNT_WIDTH-1:0] rsp_x,
    output logic [CNT_WIDTH-1:0] rsp_y,
    output logic [31:0]          perf_stall_cycles
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] X_LAST     = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] Y_LAST     = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [3:0]           CREDIT_MAX = 4'(MAX_OUTSTANDING);

    logic [1:0] state;
    logic [2:0] acc;
    logic [3:0] credits;
    logic       active;
    logic       can_issue;
    logic       issue;
    logic       rsp_fire;
    logic       last_req;
    logic       last_rsp;

    // Combinational fork/join and status decode
    always_comb begin
        active          = (state == S_RUN) || (state == S_DRAIN);
        can_issue       = (state == S_RUN) && (credits < CREDIT_MAX);
        ch_req_valid    = {3{bf_req_valid & can_issue}} & ~acc;
        issue           = bf_req_valid & can_issue & (&(acc | (ch_req_valid & ch_req_ready)));
        sched_req_ready = issue;
        sched_rsp_valid = active & (&ch_rsp_valid);
        rsp_fire        = sched_rsp_valid & bf_rsp_ready;
        ch_rsp_ready    = {3{rsp_fire}};
        busy            = active;
        done            = (state == S_DONE);
        last_req        = (req_x == X_LAST) && (req_y == Y_LAST);
        last_rsp        = (rsp_x == X_LAST) && (rsp_y == Y_LAST);
    end

    // Frame state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (issue && last_req) state <= S_DRAIN;
                S_DRAIN: if (rsp_fire && last_rsp) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-channel accepted flags; cleared once the whole window has issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (issue) begin
            acc <= '0;
        end else begin
            acc <= acc | (ch_req_valid & ch_req_ready);
        end
    end

    // Credit counter; a simultaneous issue and response leaves it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= '0;
        end else begin
            case ({issue, rsp_fire})
                2'b10:   credits <= credits + 4'd1;
                2'b01:   credits <= credits - 4'd1;
                default: credits <= credits;
            endcase
        end
    end

    // Request coordinate, raster order, wrapping to (0,0) after the last window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_x <= '0;
            req_y <= '0;
        end else if (issue) begin
            if (req_x == X_LAST) begin
                req_x <= '0;
                req_y <= (req_y == Y_LAST) ? '0 : req_y + 1'b1;
            end else begin
                req_x <= req_x + 1'b1;
            end
        end
    end

    // Response coordinate; relies on in-order responses from the channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_x <= '0;
            rsp_y <= '0;
        end else if (rsp_fire) begin
            if (rsp_x == X_LAST) begin
                rsp_x <= '0;
                rsp_y <= (rsp_y == Y_LAST) ? '0 : rsp_y + 1'b1;
            end else begin
                rsp_x <= rsp_x + 1'b1;
            end
        end
    end

`ifdef BICUBIC_SCHED_PERF_EN
    // Saturating count of RUN cycles where the buffer offered a window but none issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_stall_cycles <= '0;
        end else if ((state == S_RUN) && bf_req_valid && !issue && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_bicubic_sched.sv
// Self-checking bench for bicubic_sched: directed scenarios plus randomized
// frames, checked every cycle against a count-based behavioural model.
module tb_bicubic_sched;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int N   = W * H;
    localparam int MAX = 3;
    localparam int CW  = 12;
`ifdef BICUBIC_SCHED_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          bf_req_valid;
    logic          sched_req_ready;
    logic [2:0]    ch_req_valid;
    logic [2:0]    ch_req_ready;
    logic [CW-1:0] req_x;
    logic [CW-1:0] req_y;
    logic [2:0]    ch_rsp_valid;
    logic [2:0]    ch_rsp_ready;
    logic          sched_rsp_valid;
    logic          bf_rsp_ready;
    logic [CW-1:0] rsp_x;
    logic [CW-1:0] rsp_y;
    logic [31:0]   perf_stall_cycles;

    bicubic_sched #(
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H),
        .MAX_OUTSTANDING(MAX),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .bf_req_valid(bf_req_valid),
        .sched_req_ready(sched_req_ready),
        .ch_req_valid(ch_req_valid),
        .ch_req_ready(ch_req_ready),
        .req_x(req_x),
        .req_y(req_y),
        .ch_rsp_valid(ch_rsp_valid),
        .ch_rsp_ready(ch_rsp_ready),
        .sched_rsp_valid(sched_rsp_valid),
        .bf_rsp_ready(bf_rsp_ready),
        .rsp_x(rsp_x),
        .rsp_y(rsp_y),
        .perf_stall_cycles(perf_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A response handshake must always retire an outstanding window
    assert property (@(posedge clk) disable iff (!rst_n) (|ch_rsp_ready) |-> (dut.credits != 4'd0))
        else $error("FAIL credit_underflow: response handshake with zero credits");

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural model: frame progress as window counts, channels as FIFOs
    int          cyc = 0;
    int          issued, retired;
    bit          m_active, m_done;
    bit [2:0]    got;
    logic [31:0] m_perf;
    int          qt[3][16];
    int          qh[3];
    int          qn[3];
    int          lat_min = 1, lat_max = 1;

    // Observations from the most recent step
    logic [2:0]  obs_chv, obs_rspr;
    logic        obs_srr, obs_srv;
    logic [31:0] obs_rx, obs_perf;
    int          obs_issues, obs_done, first_issue, last_issue;

    task automatic model_clear();
        issued = 0; retired = 0; m_active = 0; m_done = 0; got = '0; m_perf = '0;
        for (int i = 0; i < 3; i++) begin qh[i] = 0; qn[i] = 0; end
    endtask

    task automatic step(input logic st, input logic bf, input logic [2:0] rdy,
                        input logic brr, input logic [2:0] mask);
        logic [2:0] e_chv, e_rspr;
        logic       e_srr, e_join, e_run, e_can, idle, stall;
        @(posedge clk);
        #1;
        start        = st;
        bf_req_valid = bf;
        ch_req_ready = rdy;
        bf_rsp_ready = brr;
        for (int i = 0; i < 3; i++)
            ch_rsp_valid[i] = (qn[i] > 0) && (qt[i][qh[i]] <= cyc) && mask[i];
        #3;
        idle  = !m_active && !m_done;
        e_run = m_active && (issued < N);
        e_can = e_run && ((issued - retired) < MAX) && bf;
        for (int i = 0; i < 3; i++) e_chv[i] = e_can && !got[i];
        e_srr  = e_can && (&(got | (e_chv & rdy)));
        e_join = m_active && (&ch_rsp_valid);
        e_rspr = {3{e_join && brr}};

        check("busy", busy, m_active);
        check("done", done, m_done);
        check("ch_req_valid", ch_req_valid, e_chv);
        check("sched_req_ready", sched_req_ready, e_srr);
        check("sched_rsp_valid", sched_rsp_valid, e_join);
        check("ch_rsp_ready", ch_rsp_ready, e_rspr);
        check("req_x", req_x, (issued % N) % W);
        check("req_y", req_y, (issued % N) / W);
        check("rsp_x", rsp_x, (retired % N) % W);
        check("rsp_y", rsp_y, (retired % N) / W);
        check("perf_stall_cycles", perf_stall_cycles, PERF_EN ? m_perf : 32'd0);

        obs_chv  = ch_req_valid;
        obs_rspr = ch_rsp_ready;
        obs_srr  = sched_req_ready;
        obs_srv  = sched_rsp_valid;
        obs_rx   = 32'(req_x);
        obs_perf = perf_stall_cycles;
        if (sched_req_ready === 1'b1) begin
            if (obs_issues == 0) first_issue = cyc;
            last_issue = cyc;
            obs_issues++;
        end
        if (done === 1'b1) obs_done++;

        // Advance the model to the state after the coming clock edge
        stall = e_run && bf && !e_srr;
        for (int i = 0; i < 3; i++) begin
            if (e_chv[i] && rdy[i]) begin
                qt[i][(qh[i] + qn[i]) % 16] = cyc + $urandom_range(lat_max, lat_min);
                qn[i]++;
                got[i] = 1'b1;
            end
        end
        if (e_srr) begin
            got = '0;
            issued++;
        end
        m_done = 1'b0;
        if (e_join && brr) begin
            for (int i = 0; i < 3; i++) begin qh[i] = (qh[i] + 1) % 16; qn[i]--; end
            retired++;
            if (retired == N) begin m_active = 1'b0; m_done = 1'b1; end
        end
        if (idle && st) begin
            m_active = 1'b1; issued = 0; retired = 0; got = '0; m_perf = '0;
        end else if (stall && m_perf != 32'hFFFF_FFFF) begin
            m_perf = m_perf + 32'd1;
        end
        cyc++;
    endtask

    task automatic clear_obs();
        obs_issues = 0; obs_done = 0; first_issue = 0; last_issue = 0;
    endtask

    // Run random traffic until the model returns to IDLE, bounded
    task automatic finish_frame(input bit all_ready);
        int n = 0;
        while ((m_active || m_done) && n < 2000) begin
            if (all_ready) step(1'b0, 1'b1, 3'b111, 1'b1, 3'b111);
            else step(1'b0, ($urandom % 4) != 0, 3'($urandom), ($urandom % 4) != 0,
                      3'($urandom) | 3'($urandom));
            n++;
        end
        check("frame_timeout", (n >= 2000), 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0; bf_req_valid = 1'b0; ch_req_ready = '0;
        ch_rsp_valid = '0; bf_rsp_ready = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ch_req_valid", ch_req_valid, 3'b000);
        check("rst_sched_req_ready", sched_req_ready, 1'b0);
        check("rst_ch_rsp_ready", ch_rsp_ready, 3'b000);
        check("rst_sched_rsp_valid", sched_rsp_valid, 1'b0);
        check("rst_req_xy", {req_x, req_y}, 24'd0);
        check("rst_rsp_xy", {rsp_x, rsp_y}, 24'd0);
        check("rst_perf", perf_stall_cycles, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int bi;
        rst_n = 1'b0;
        start = 1'b0; bf_req_valid = 1'b0; ch_req_ready = '0;
        ch_rsp_valid = '0; bf_rsp_ready = 1'b0;
        model_clear();
        do_reset();

        // Basic frame: all ready, responses two cycles after issue
        lat_min = 2; lat_max = 2;
        clear_obs();
        step(1'b1, 1'b1, 3'b111, 1'b1, 3'b111);
        finish_frame(1'b1);
        step(1'b0, 1'b0, 3'b000, 1'b1, 3'b111);
        check("basic_issues", obs_issues, N);
        check("basic_consecutive", last_issue - first_issue, N - 1);
        check("basic_done_once", obs_done, 1);

        // Skewed channel readiness: window issues only when the last channel accepts
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 3'b000, 1'b1, 3'b111);
        step(1'b0, 1'b1, 3'b100, 1'b1, 3'b000);
        check("skew1_chv", obs_chv, 3'b111);
        check("skew1_srr", obs_srr, 1'b0);
        step(1'b0, 1'b1, 3'b010, 1'b1, 3'b000);
        check("skew2_chv", obs_chv, 3'b011);
        check("skew2_srr", obs_srr, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b1, 3'b000);
        check("skew3_chv", obs_chv, 3'b001);
        check("skew3_srr", obs_srr, 1'b1);
        step(1'b0, 1'b0, 3'b000, 1'b1, 3'b000);
        check("skew_req_x", obs_rx, 32'd1);
        finish_frame(1'b0);

        // Credit limit with responses withheld; also five stall cycles
        clear_obs();
        step(1'b1, 1'b1, 3'b111, 1'b1, 3'b000);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'b111, 1'b1, 3'b000);
        check("credit_issues", obs_issues, MAX);
        step(1'b0, 1'b0, 3'b111, 1'b1, 3'b000);
        check("perf_five_stalls", obs_perf, PERF_EN ? 32'd5 : 32'd0);
        clear_obs();
        step(1'b0, 1'b1, 3'b111, 1'b1, 3'b111);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b111, 1'b1, 3'b000);
        check("credit_one_more", obs_issues, 1);
        finish_frame(1'b0);

        // Partial response valid never retires any channel
        step(1'b1, 1'b0, 3'b000, 1'b1, 3'b000);
        step(1'b0, 1'b1, 3'b111, 1'b1, 3'b000);
        step(1'b0, 1'b1, 3'b111, 1'b1, 3'b000);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 3'b000, 1'b1, 3'b110);
            check("partial_rsp_ready", obs_rspr, 3'b000);
            check("partial_rsp_valid", obs_srv, 1'b0);
        end
        step(1'b0, 1'b0, 3'b000, 1'b1, 3'b111);
        check("partial_complete", obs_rspr, 3'b111);
        finish_frame(1'b0);

        // Reset mid-frame after three issues, then restart
        clear_obs();
        step(1'b1, 1'b1, 3'b111, 1'b1, 3'b000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b111, 1'b1, 3'b000);
        check("pre_reset_issues", obs_issues, 3);
        do_reset();
        step(1'b1, 1'b1, 3'b111, 1'b1, 3'b000);
        clear_obs();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'b111, 1'b1, 3'b000);
        check("restart_full_credits", obs_issues, MAX);
        finish_frame(1'b0);

        // Randomized frames with variable response latency
        lat_min = 1; lat_max = 4;
        for (int f = 0; f < 6; f++) begin
            clear_obs();
            bi = $urandom_range(3, 0);
            for (int i = 0; i < bi; i++) step(1'b0, 1'b1, 3'($urandom), 1'b1, 3'b111);
            step(1'b1, ($urandom % 2) != 0, 3'($urandom), 1'b1, 3'b111);
            finish_frame(1'b0);
            step(1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
            check("rand_done_once", obs_done, 1);
            check("rand_issues", obs_issues, N);
            finish_frame(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
